// File: rtl/race_epoch_sequencer_if.sv
// rtl/race_epoch_sequencer_if.sv - host-side epoch request/result bundle for race_epoch_sequencer
interface race_epoch_sequencer_if #(
  parameter int N_IN = 2,
  parameter int TW   = 4
);
  logic                 start;
  logic [N_IN*TW-1:0]   in_time;
  logic                 busy;
  logic                 done;
  logic [TW-1:0]        result;
  logic                 timeout;

  modport master (output start, output in_time,
                  input  busy,  input  done, input result, input timeout);
  modport slave  (input  start, input  in_time,
                  output busy,  output done, output result, output timeout);
endinterface

// File: rtl/race_epoch_sequencer.sv
// rtl/race_epoch_sequencer.sv - sequences one race-logic epoch: set, timed launches, q timestamp
// RACE_FALLING_EN selects falling-edge coding (idle level 1); default is rising-edge coding.
module race_epoch_sequencer #(
  parameter int N_IN    = 2,
  parameter int TW      = 4,
  parameter int SET_CYC = 1
) (
  input  logic                    aclk,
  input  logic                    grst,
  race_epoch_sequencer_if.slave   host,
  output logic                    set,
  output logic [N_IN-1:0]         edge_out,
  input  logic                    q_in
);

`ifdef RACE_FALLING_EN
  localparam logic IDLE_LVL = 1'b1;
`else
  localparam logic IDLE_LVL = 1'b0;
`endif
  localparam logic ACT_LVL = ~IDLE_LVL;

  localparam int SCW = (SET_CYC > 1) ? $clog2(SET_CYC) : 1;
  localparam logic [TW-1:0] NEVER   = '1;
  localparam logic [TW-1:0] T_LIMIT = {{(TW-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {IDLE, SET, RUN, DONE} state_t;

  state_t           state;
  logic [SCW-1:0]   set_cnt;
  logic [TW-1:0]    t;
  logic [TW-1:0]    tim [N_IN];
  logic             q_prev;

  logic [TW-1:0]    t_nxt;
  logic             q_edge;
  logic [N_IN-1:0]  lvl_first;
  logic [N_IN-1:0]  lvl_nxt;

  // Launch levels are computed one cycle ahead so the registered lane is
  // already active during the cycle whose t equals its programmed time.
  always_comb begin
    t_nxt     = t + 1'b1;
    q_edge    = (q_in == ACT_LVL) && (q_prev == IDLE_LVL);
    lvl_first = '0;
    lvl_nxt   = '0;
    for (int i = 0; i < N_IN; i++) begin
      lvl_first[i] = (tim[i] == '0) ? ACT_LVL : IDLE_LVL;
      lvl_nxt[i]   = ((edge_out[i] == ACT_LVL) ||
                      ((tim[i] != NEVER) && (tim[i] == t_nxt))) ? ACT_LVL : IDLE_LVL;
    end
  end

  always_ff @(posedge aclk or negedge grst) begin
    if (!grst) begin
      state        <= IDLE;
      set_cnt      <= '0;
      t            <= '0;
      q_prev       <= IDLE_LVL;
      set          <= 1'b0;
      edge_out     <= {N_IN{IDLE_LVL}};
      host.busy    <= 1'b0;
      host.done    <= 1'b0;
      host.result  <= '0;
      host.timeout <= 1'b0;
      for (int i = 0; i < N_IN; i++) tim[i] <= '0;
    end else begin
      host.done <= 1'b0;
      case (state)
        IDLE: begin
          if (host.start) begin
            for (int i = 0; i < N_IN; i++) tim[i] <= host.in_time[i*TW +: TW];
            state     <= SET;
            set       <= 1'b1;
            host.busy <= 1'b1;
            set_cnt   <= '0;
            t         <= '0;
            q_prev    <= IDLE_LVL;
            edge_out  <= {N_IN{IDLE_LVL}};
          end
        end
        SET: begin
          if (set_cnt == SCW'(SET_CYC - 1)) begin
            state    <= RUN;
            set      <= 1'b0;
            t        <= '0;
            edge_out <= lvl_first;
          end else begin
            set_cnt <= set_cnt + 1'b1;
          end
        end
        RUN: begin
          q_prev <= q_in;
          // A q edge coinciding with the time limit is still a valid result.
          if (q_edge) begin
            host.result  <= t;
            host.timeout <= 1'b0;
            host.done    <= 1'b1;
            state        <= DONE;
          end else if (t == T_LIMIT) begin
            host.result  <= NEVER;
            host.timeout <= 1'b1;
            host.done    <= 1'b1;
            state        <= DONE;
          end else begin
            t        <= t_nxt;
            edge_out <= lvl_nxt;
          end
        end
        DONE: begin
          state     <= IDLE;
          host.busy <= 1'b0;
          edge_out  <= {N_IN{IDLE_LVL}};
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_race_epoch_sequencer.sv
// tb/tb_race_epoch_sequencer.sv - scoreboard bench for race_epoch_sequencer driving an exclusive_max primitive
module tb_race_epoch_sequencer;

`ifdef RACE_FALLING_EN
  localparam logic IDLE_LVL = 1'b1;
`else
  localparam logic IDLE_LVL = 1'b0;
`endif
  localparam logic ACT_LVL = ~IDLE_LVL;

  typedef struct packed {
    logic [3:0] res;
    logic       to;
    logic [3:0] la;
    logic [3:0] lb;
    logic [3:0] et;
  } exp_t;

  logic       aclk = 1'b0;
  logic       grst = 1'b0;
  logic       set;
  logic [1:0] edge_out;
  logic       q_in;

  int checks = 0;
  int errors = 0;
  exp_t sbq[$];

  race_epoch_sequencer_if #(.N_IN(2), .TW(4)) hif ();

  race_epoch_sequencer #(.N_IN(2), .TW(4), .SET_CYC(1)) dut (
    .aclk     (aclk),
    .grst     (grst),
    .host     (hif),
    .set      (set),
    .edge_out (edge_out),
    .q_in     (q_in)
  );

  // exclusive_max: q reaches its active level once both inputs have
`ifdef RACE_FALLING_EN
  assign q_in = edge_out[0] | edge_out[1];
`else
  assign q_in = edge_out[0] & edge_out[1];
`endif

  always #5 aclk = ~aclk;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Monitor: measures set length, per-lane launch time and run length, compares on done.
  int         phase = 0;
  int         set_len;
  int         rt;
  logic [3:0] lt0, lt1;
  exp_t       e;

  always @(negedge aclk) begin
    if (!grst) begin
      phase = 0;
    end else if (set) begin
      if (phase != 1) begin
        phase = 1; set_len = 0; rt = 0; lt0 = 4'hF; lt1 = 4'hF;
      end
      set_len++;
    end else if (phase == 1) begin
      if (hif.done) begin
        if (sbq.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("result", int'(hif.result), int'(e.res));
          chk("timeout", int'(hif.timeout), int'(e.to));
          chk("set_cycles", set_len, 1);
          chk("run_cycles", rt, int'(e.et) + 1);
          chk("launch_a", int'(lt0), int'(e.la));
          chk("launch_b", int'(lt1), int'(e.lb));
        end
        phase = 0;
      end else begin
        if (edge_out[0] == ACT_LVL && lt0 == 4'hF) lt0 = 4'(rt);
        if (edge_out[1] == ACT_LVL && lt1 == 4'hF) lt1 = 4'(rt);
        rt++;
      end
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic kick(input logic [3:0] a, input logic [3:0] b);
    hif.in_time = {b, a};
    hif.start   = 1'b1;
    tick();
    hif.start   = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (hif.busy && n < 40) begin tick(); n++; end
    if (hif.busy) chk("busy_timeout", 1, 0);
  endtask

  task automatic run_epoch(input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] res, input logic to);
    exp_t x;
    x.res = res; x.to = to; x.la = a; x.lb = b;
    x.et  = to ? 4'd14 : res;
    sbq.push_back(x);
    kick(a, b);
    wait_idle();
    tick();
  endtask

  task automatic wait_run(input int cycles);
    int n = 0;
    while (!set && n < 20) begin tick(); n++; end
    while (set && n < 20) begin tick(); n++; end
    if (n >= 20) chk("set_timeout", 1, 0);
    repeat (cycles) tick();
  endtask

  initial begin
    hif.start   = 1'b0;
    hif.in_time = '0;
    tick();
    chk("rst_busy", int'(hif.busy), 0);
    chk("rst_set", int'(set), 0);
    chk("rst_done", int'(hif.done), 0);
    chk("rst_timeout", int'(hif.timeout), 0);
    chk("rst_result", int'(hif.result), 0);
    chk("rst_edge_out", int'(edge_out), int'({2{IDLE_LVL}}));
    grst = 1'b1;
    tick();

    run_epoch(4'd3,  4'd7,  4'd7,  1'b0);
    run_epoch(4'd5,  4'd2,  4'd5,  1'b0);
    run_epoch(4'd4,  4'd4,  4'd4,  1'b0);
    run_epoch(4'd0,  4'd0,  4'd0,  1'b0);
    run_epoch(4'd14, 4'd3,  4'd14, 1'b0);
    run_epoch(4'd15, 4'd2,  4'd15, 1'b1);

    // Abort during RUN at t=3: reset values must appear without a clock edge.
    kick(4'd3, 4'd7);
    wait_run(3);
    #2 grst = 1'b0;
    #1;
    chk("abort_busy", int'(hif.busy), 0);
    chk("abort_set", int'(set), 0);
    chk("abort_done", int'(hif.done), 0);
    chk("abort_timeout", int'(hif.timeout), 0);
    chk("abort_result", int'(hif.result), 0);
    chk("abort_edge_out", int'(edge_out), int'({2{IDLE_LVL}}));
    tick();
    grst = 1'b1;
    tick();
    run_epoch(4'd1, 4'd0, 4'd1, 1'b0);

    // Mid-epoch start and in_time change must not disturb the captured epoch.
    begin
      exp_t x;
      x.res = 4'd5; x.to = 1'b0; x.la = 4'd2; x.lb = 4'd5; x.et = 4'd5;
      sbq.push_back(x);
      kick(4'd2, 4'd5);
      wait_run(1);
      kick(4'd6, 4'd1);
      wait_idle();
      repeat (6) tick();
      chk("no_queued_epoch", int'(hif.busy), 0);
    end

    chk("scoreboard_empty", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
